// File: rtl/get_data_pkg.sv
// ---------------------------------------------------------------------------
// get_data_pkg
// Shared types and default parameter constants for the get_data pipe.
//   state_t : FSM states of get_data_pipe
//   tag_t   : marker travelling alongside each ROM read, telling the
//             returning data which output register(s) it belongs to
//   tag_has_k / tag_has_l : decode a returning tag
// ---------------------------------------------------------------------------
package get_data_pkg;

    localparam int DEF_IDX_W   = 7;
    localparam int DEF_Z_W     = 3;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ROM_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_K,
        ST_RD_L,
        ST_WAIT,
        ST_OUT
    } state_t;

    // TAG_KL marks a single read whose word serves both k and l.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_K,
        TAG_L,
        TAG_KL
    } tag_t;

    function automatic logic tag_has_k(input tag_t t);
        return (t == TAG_K) || (t == TAG_KL);
    endfunction

    function automatic logic tag_has_l(input tag_t t);
        return (t == TAG_L) || (t == TAG_KL);
    endfunction

endpackage

// File: rtl/rom_rd_tracker.sv
// ---------------------------------------------------------------------------
// rom_rd_tracker
// LAT-deep shift register of read tags. A tag entering with a ROM request
// leaves exactly LAT cycles later, aligned with the ROM's read data.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears every stage to TAG_NONE
//   i_tag : tag of the read issued this cycle (TAG_NONE if no read)
//   o_tag : tag matching the rom_rdata present this cycle
// LAT must lie in 1..4.
// ---------------------------------------------------------------------------
module rom_rd_tracker
    import get_data_pkg::*;
#(
    parameter int LAT = DEF_ROM_LAT
) (
    input  logic clk,
    input  logic rst,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_tag [LAT];

    // NOTE: this pipeline is reset even though it is only a shift register,
    // because it carries control: a tag surviving reset would steer late ROM
    // data into the output registers after the tuple was discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < LAT; n++) begin
                r_tag[n] <= TAG_NONE;
            end
        end else begin
            r_tag[0] <= i_tag;
            for (int n = 1; n < LAT; n++) begin
                r_tag[n] <= r_tag[n-1];
            end
        end
    end

    assign o_tag = r_tag[LAT-1];

endmodule

// File: rtl/get_data_pipe.sv
// ---------------------------------------------------------------------------
// get_data_pipe
// Accepts a (i, z, k, l) tuple, reads ROM words at k and l and presents
// them with the echoed tuple on a valid/ready output. An empty interval
// (k > l) skips the ROM and is reported through out_empty.
// Optional feature macro: GET_DATA_SAME_ADDR_EN -- when defined, k == l
// issues a single ROM read whose word is written to both data outputs.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : tuple handshake (ready only in IDLE)
//   in_i/in_z/in_k/in_l           : tuple
//   rom_en/rom_addr/rom_rdata     : ROM port, data ROM_LAT cycles after en
//   out_valid/out_ready           : result handshake
//   out_i/out_z/out_k/out_l       : echoed tuple
//   out_data_k/out_data_l         : ROM words at k and l
//   out_empty                     : k > l
//   busy                          : FSM not in IDLE
// ---------------------------------------------------------------------------
module get_data_pipe
    import get_data_pkg::*;
#(
    parameter int IDX_W   = DEF_IDX_W,
    parameter int Z_W     = DEF_Z_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = DEF_ROM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_i,
    input  logic [Z_W-1:0]    in_z,
    input  logic [ADDR_W-1:0] in_k,
    input  logic [ADDR_W-1:0] in_l,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_i,
    output logic [Z_W-1:0]    out_z,
    output logic [ADDR_W-1:0] out_k,
    output logic [ADDR_W-1:0] out_l,
    output logic [DATA_W-1:0] out_data_k,
    output logic [DATA_W-1:0] out_data_l,
    output logic              out_empty,
    output logic              busy
);

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_i;
    logic [Z_W-1:0]      r_z;
    logic [ADDR_W-1:0]   r_k;
    logic [ADDR_W-1:0]   r_l;
    logic [DATA_W-1:0]   r_data_k;
    logic [DATA_W-1:0]   r_data_l;
    logic                r_empty;
    logic                w_accept;
    logic                w_same;
    tag_t                w_tag_issue;
    tag_t                w_tag_ret;

    assign w_accept = in_valid & in_ready;

`ifdef GET_DATA_SAME_ADDR_EN
    assign w_same = (r_k == r_l);
`else
    assign w_same = 1'b0;
`endif

    rom_rd_tracker #(
        .LAT (ROM_LAT)
    ) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_issue),
        .o_tag (w_tag_ret)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        rom_en      = 1'b0;
        rom_addr    = '0;
        w_tag_issue = TAG_NONE;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_k > in_l) begin
                        w_next = ST_OUT;
                    end else begin
                        w_next = ST_RD_K;
                    end
                end
            end
            ST_RD_K: begin
                rom_en   = 1'b1;
                rom_addr = r_k;
                if (w_same) begin
                    w_tag_issue = TAG_KL;
                    w_next      = ST_WAIT;
                end else begin
                    w_tag_issue = TAG_K;
                    w_next      = ST_RD_L;
                end
            end
            ST_RD_L: begin
                rom_en      = 1'b1;
                rom_addr    = r_l;
                w_tag_issue = TAG_L;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                // The l word is always the last to return, so its arrival
                // completes the result.
                if (tag_has_l(w_tag_ret)) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Tuple and result registers. They only change on acceptance or when a
    // tagged word returns, neither of which can happen in OUT, so the
    // outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i      <= '0;
            r_z      <= '0;
            r_k      <= '0;
            r_l      <= '0;
            r_data_k <= '0;
            r_data_l <= '0;
            r_empty  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_i      <= in_i;
                r_z      <= in_z;
                r_k      <= in_k;
                r_l      <= in_l;
                r_data_k <= '0;
                r_data_l <= '0;
                r_empty  <= (in_k > in_l);
            end
            if (tag_has_k(w_tag_ret)) begin
                r_data_k <= rom_rdata;
            end
            if (tag_has_l(w_tag_ret)) begin
                r_data_l <= rom_rdata;
            end
        end
    end

    assign out_valid  = (r_state == ST_OUT);
    assign busy       = (r_state != ST_IDLE);
    assign out_i      = r_i;
    assign out_z      = r_z;
    assign out_k      = r_k;
    assign out_l      = r_l;
    assign out_data_k = r_data_k;
    assign out_data_l = r_data_l;
    assign out_empty  = r_empty;

endmodule

// File: tb/tb_get_data_pipe.sv
// ---------------------------------------------------------------------------
// tb_get_data_pipe
// Two instances of get_data_pipe (ROM_LAT=1 and ROM_LAT=3) receive the same
// stimulus; each has its own ROM model returning ROM[a] = a + 0x100.
// Directed scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_get_data_pipe;

    localparam int IW = 7;
    localparam int ZW = 3;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [IW-1:0] in_i;
    logic [ZW-1:0] in_z;
    logic [AW-1:0] in_k;
    logic [AW-1:0] in_l;

    // Instance with ROM_LAT=1
    logic          in_ready1, rom_en1, out_valid1, out_empty1, busy1;
    logic [AW-1:0] rom_addr1, out_k1, out_l1;
    logic [DW-1:0] rom_rdata1, out_data_k1, out_data_l1;
    logic [IW-1:0] out_i1;
    logic [ZW-1:0] out_z1;
    // Instance with ROM_LAT=3
    logic          in_ready3, rom_en3, out_valid3, out_empty3, busy3;
    logic [AW-1:0] rom_addr3, out_k3, out_l3;
    logic [DW-1:0] rom_rdata3, out_data_k3, out_data_l3;
    logic [IW-1:0] out_i3;
    logic [ZW-1:0] out_z3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    get_data_pipe #(.IDX_W(IW), .Z_W(ZW), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_i(in_i), .in_z(in_z), .in_k(in_k), .in_l(in_l),
        .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_rdata(rom_rdata1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_i(out_i1), .out_z(out_z1), .out_k(out_k1), .out_l(out_l1),
        .out_data_k(out_data_k1), .out_data_l(out_data_l1),
        .out_empty(out_empty1), .busy(busy1)
    );

    get_data_pipe #(.IDX_W(IW), .Z_W(ZW), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_i(in_i), .in_z(in_z), .in_k(in_k), .in_l(in_l),
        .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_rdata(rom_rdata3),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_i(out_i3), .out_z(out_z3), .out_k(out_k3), .out_l(out_l3),
        .out_data_k(out_data_k3), .out_data_l(out_data_l3),
        .out_empty(out_empty3), .busy(busy3)
    );

    // ROM models: filler value when not enabled so stray captures show up.
    logic [DW-1:0] rom_pipe1 [1];
    logic [DW-1:0] rom_pipe3 [3];

    always @(posedge clk) begin
        rom_pipe1[0] <= rom_en1 ? (DW'(rom_addr1) + 32'h100) : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        rom_pipe3[0] <= rom_en3 ? (DW'(rom_addr3) + 32'h100) : 32'hDEAD_BEEF;
        rom_pipe3[1] <= rom_pipe3[0];
        rom_pipe3[2] <= rom_pipe3[1];
    end

    assign rom_rdata1 = rom_pipe1[0];
    assign rom_rdata3 = rom_pipe3[2];

    typedef struct {
        logic          valid, ready, busy, en, empty;
        logic [AW-1:0] addr, k, l;
        logic [IW-1:0] i;
        logic [ZW-1:0] z;
        logic [DW-1:0] dk, dl;
    } snap_t;

    function automatic snap_t snap(input int d);
        snap_t s;
        if (d == 0) begin
            s.valid = out_valid1; s.ready = in_ready1; s.busy = busy1;
            s.en = rom_en1; s.empty = out_empty1; s.addr = rom_addr1;
            s.k = out_k1; s.l = out_l1; s.i = out_i1; s.z = out_z1;
            s.dk = out_data_k1; s.dl = out_data_l1;
        end else begin
            s.valid = out_valid3; s.ready = in_ready3; s.busy = busy3;
            s.en = rom_en3; s.empty = out_empty3; s.addr = rom_addr3;
            s.k = out_k3; s.l = out_l3; s.i = out_i3; s.z = out_z3;
            s.dk = out_data_k3; s.dl = out_data_l3;
        end
        return s;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Issue one tuple with out_ready=1 and watch 14 cycles on both instances.
    task automatic run_tuple(input string name,
                             input logic [IW-1:0] ti, input logic [ZW-1:0] tz,
                             input logic [AW-1:0] tk, input logic [AW-1:0] tl,
                             input logic [DW-1:0] edk, input logic [DW-1:0] edl,
                             input logic eempty, input int ecount, input int ebase);
        int            cyc [2];
        int            cnt [2];
        int            bad [2];
        logic [AW-1:0] a0 [2];
        logic [AW-1:0] a1 [2];
        snap_t         got [2];
        snap_t         s;
        int            ecyc;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = -1; cnt[d] = 0; bad[d] = 0; a0[d] = '0; a1[d] = '0;
            got[d] = snap(d);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_i = ti; in_z = tz; in_k = tk; in_l = tl; in_valid = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            n_checks++;
            if (s.ready !== 1'b1) $display("FAIL %s_in_ready lat%0d: got %0b expected 1", name, lat_of(d), s.ready);
            else n_pass++;
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                s = snap(d);
                if (s.en === 1'b1) begin
                    cnt[d]++;
                    if (cnt[d] == 1) a0[d] = s.addr;
                    else if (cnt[d] == 2) a1[d] = s.addr;
                end else if (s.addr !== '0) begin
                    bad[d]++;
                end
                if (s.valid === 1'b1 && cyc[d] < 0) begin
                    cyc[d] = c;
                    got[d] = s;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            ecyc = eempty ? 1 : ebase + lat_of(d);
            n_checks++;
            if (cyc[d] != ecyc) $display("FAIL %s_out_cycle lat%0d: got %0d expected %0d", name, lat_of(d), cyc[d], ecyc);
            else n_pass++;
            n_checks++;
            if (cnt[d] != ecount) $display("FAIL %s_rom_reads lat%0d: got %0d expected %0d", name, lat_of(d), cnt[d], ecount);
            else n_pass++;
            if (ecount >= 1) begin
                n_checks++;
                if (a0[d] !== tk) $display("FAIL %s_addr_k lat%0d: got %0h expected %0h", name, lat_of(d), a0[d], tk);
                else n_pass++;
            end
            if (ecount == 2) begin
                n_checks++;
                if (a1[d] !== tl) $display("FAIL %s_addr_l lat%0d: got %0h expected %0h", name, lat_of(d), a1[d], tl);
                else n_pass++;
            end
            n_checks++;
            if (bad[d] != 0) $display("FAIL %s_idle_addr lat%0d: got %0d nonzero cycles expected 0", name, lat_of(d), bad[d]);
            else n_pass++;
            n_checks++;
            if (got[d].dk !== edk) $display("FAIL %s_data_k lat%0d: got %0h expected %0h", name, lat_of(d), got[d].dk, edk);
            else n_pass++;
            n_checks++;
            if (got[d].dl !== edl) $display("FAIL %s_data_l lat%0d: got %0h expected %0h", name, lat_of(d), got[d].dl, edl);
            else n_pass++;
            n_checks++;
            if (got[d].empty !== eempty) $display("FAIL %s_empty lat%0d: got %0b expected %0b", name, lat_of(d), got[d].empty, eempty);
            else n_pass++;
            n_checks++;
            if ({got[d].i, got[d].z, got[d].k, got[d].l} !== {ti, tz, tk, tl})
                $display("FAIL %s_tuple lat%0d: got %0h expected %0h", name, lat_of(d),
                         {got[d].i, got[d].z, got[d].k, got[d].l}, {ti, tz, tk, tl});
            else n_pass++;
            s = snap(d);
            n_checks++;
            if ({s.ready, s.busy} !== 2'b10) $display("FAIL %s_back_idle lat%0d: got ready,busy=%0b expected 10", name, lat_of(d), {s.ready, s.busy});
            else n_pass++;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        snap_t s;
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            n_checks++;
            if ({s.ready, s.valid, s.en, s.busy, s.empty} !== 5'b10000)
                $display("FAIL %s_ctrl lat%0d: got rdy,vld,en,busy,empty=%0b expected 10000", name, lat_of(d),
                         {s.ready, s.valid, s.en, s.busy, s.empty});
            else n_pass++;
            n_checks++;
            if ({s.addr, s.i, s.z, s.k, s.l, s.dk, s.dl} !== '0)
                $display("FAIL %s_data lat%0d: got addr=%0h tuple=%0h dk=%0h dl=%0h expected all 0", name, lat_of(d),
                         s.addr, {s.i, s.z, s.k, s.l}, s.dk, s.dl);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_i = '0; in_z = '0; in_k = '0; in_l = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_tuple("basic", 7'd5, 3'd1, 12'd10, 12'd20, 32'h10A, 32'h114, 1'b0, 2, 3);
    endtask

    task automatic test_extremes();
        run_tuple("extremes", 7'd127, 3'd7, 12'd0, 12'd4095, 32'h100, 32'h10FF, 1'b0, 2, 3);
    endtask

    task automatic test_empty();
        run_tuple("empty", 7'd9, 3'd2, 12'd9, 12'd3, 32'h0, 32'h0, 1'b1, 0, 1);
    endtask

    task automatic test_same_addr();
`ifdef GET_DATA_SAME_ADDR_EN
        run_tuple("same", 7'd11, 3'd4, 12'd7, 12'd7, 32'h107, 32'h107, 1'b0, 1, 2);
`else
        run_tuple("same", 7'd11, 3'd4, 12'd7, 12'd7, 32'h107, 32'h107, 1'b0, 2, 3);
`endif
    endtask

    task automatic test_stall();
        snap_t s;
        out_ready = 1'b0;
        @(negedge clk);
        in_i = 7'd3; in_z = 3'd2; in_k = 12'd100; in_l = 12'd200; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < 2; d++) begin
                s = snap(d);
                n_checks++;
                if ({s.valid, s.ready, s.empty, s.i, s.z, s.k, s.l, s.dk, s.dl} !==
                    {1'b1, 1'b0, 1'b0, 7'd3, 3'd2, 12'd100, 12'd200, 32'h164, 32'h1C8})
                    $display("FAIL stall_hold lat%0d cyc%0d: got vld=%0b rdy=%0b dk=%0h dl=%0h expected vld=1 rdy=0 dk=164 dl=1c8",
                             lat_of(d), c, s.valid, s.ready, s.dk, s.dl);
                else n_pass++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            n_checks++;
            if ({s.ready, s.valid} !== 2'b10) $display("FAIL stall_release lat%0d: got rdy,vld=%0b expected 10", lat_of(d), {s.ready, s.valid});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        snap_t s;
        out_ready = 1'b1;
        @(negedge clk);
        in_i = 7'd6; in_z = 3'd5; in_k = 12'd30; in_l = 12'd40; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        // Old reads are still returning from the ROM models; nothing may land.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                s = snap(d);
                n_checks++;
                if ({s.valid, s.busy, s.dk, s.dl} !== '0)
                    $display("FAIL rst_late_data lat%0d cyc%0d: got vld=%0b busy=%0b dk=%0h dl=%0h expected all 0",
                             lat_of(d), c, s.valid, s.busy, s.dk, s.dl);
                else n_pass++;
            end
        end
        run_tuple("after_rst", 7'd2, 3'd3, 12'd30, 12'd41, 32'h11E, 32'h129, 1'b0, 2, 3);
    endtask

    task automatic test_back_to_back();
        run_tuple("b2b_a", 7'd64, 3'd0, 12'd1, 12'd2, 32'h101, 32'h102, 1'b0, 2, 3);
`ifdef GET_DATA_SAME_ADDR_EN
        run_tuple("b2b_top", 7'd1, 3'd6, 12'd4095, 12'd4095, 32'h10FF, 32'h10FF, 1'b0, 1, 2);
`else
        run_tuple("b2b_top", 7'd1, 3'd6, 12'd4095, 12'd4095, 32'h10FF, 32'h10FF, 1'b0, 2, 3);
`endif
        run_tuple("b2b_empty", 7'd0, 3'd0, 12'd4095, 12'd0, 32'h0, 32'h0, 1'b1, 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_empty();
        test_same_addr();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
